// File: rtl/cfr_regs_mc.sv
// Multi-channel CFR register bank: IPIF slave with double-buffered per-channel PC-CFR/HC controls,
// commit FSM (immediate or frame-aligned) and CPW coefficient write port. Option: CFR_REGS_MC_CLIP_CNT_EN.

module cfr_regs_mc_ch #(
    parameter int TH_WIDTH  = 17,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_i,
    input  logic [3:0]           wr_off_i,
    input  logic [TH_WIDTH-1:0]  wdat_i,
    input  logic                 apply_i,
    input  logic                 rd_clr_i,
    input  logic                 clip_i,
    output logic                 sh_pc_en_o,
    output logic                 sh_hc_en_o,
    output logic [TH_WIDTH-1:0]  sh_det_o,
    output logic [TH_WIDTH-1:0]  sh_clip_o,
    output logic [TH_WIDTH-1:0]  sh_hc_o,
    output logic                 act_pc_en_o,
    output logic                 act_hc_en_o,
    output logic [TH_WIDTH-1:0]  act_det_o,
    output logic [TH_WIDTH-1:0]  act_clip_o,
    output logic [TH_WIDTH-1:0]  act_hc_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic                sh_pc_en_q, sh_hc_en_q, act_pc_en_q, act_hc_en_q;
    logic [TH_WIDTH-1:0] sh_det_q, sh_clip_q, sh_hc_q, act_det_q, act_clip_q, act_hc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_pc_en_q <= 1'b0;
            sh_hc_en_q <= 1'b0;
            sh_det_q   <= '1;
            sh_clip_q  <= '1;
            sh_hc_q    <= '1;
        end else if (wr_i) begin
            case (wr_off_i)
                4'h0: begin
                    sh_pc_en_q <= wdat_i[0];
                    sh_hc_en_q <= wdat_i[1];
                end
                4'h1: sh_det_q  <= wdat_i;
                4'h2: sh_clip_q <= wdat_i;
                4'h3: sh_hc_q   <= wdat_i;
                default: ;
            endcase
        end
    end

    // Active copy samples the pre-edge shadow, so a same-cycle shadow write misses this commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_pc_en_q <= 1'b0;
            act_hc_en_q <= 1'b0;
            act_det_q   <= '1;
            act_clip_q  <= '1;
            act_hc_q    <= '1;
        end else if (apply_i) begin
            act_pc_en_q <= sh_pc_en_q;
            act_hc_en_q <= sh_hc_en_q;
            act_det_q   <= sh_det_q;
            act_clip_q  <= sh_clip_q;
            act_hc_q    <= sh_hc_q;
        end
    end

`ifdef CFR_REGS_MC_CLIP_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rd_clr_i)
            cnt_d = clip_i ? CNT_WIDTH'(1) : '0;
        else if (clip_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, rd_clr_i, clip_i};
    assign cnt_o     = '0;
`endif

    assign sh_pc_en_o  = sh_pc_en_q;
    assign sh_hc_en_o  = sh_hc_en_q;
    assign sh_det_o    = sh_det_q;
    assign sh_clip_o   = sh_clip_q;
    assign sh_hc_o     = sh_hc_q;
    assign act_pc_en_o = act_pc_en_q;
    assign act_hc_en_o = act_hc_en_q;
    assign act_det_o   = act_det_q;
    assign act_clip_o  = act_clip_q;
    assign act_hc_o    = act_hc_q;

endmodule

module cfr_regs_mc #(
    parameter logic [31:0] ID         = 32'h0,
    parameter int          NUM_CH     = 2,
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter int          TH_WIDTH   = 17,
    parameter int          CPW_DEPTH  = 256,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic                         wr_req,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_ack,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic                         rd_req,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_ack,
    input  logic                         frame_sync,
    input  logic [NUM_CH-1:0]            clip_event,
    output logic [NUM_CH-1:0]            ctrl_pc_enable,
    output logic [NUM_CH*TH_WIDTH-1:0]   ctrl_pc_det_th,
    output logic [NUM_CH*TH_WIDTH-1:0]   ctrl_pc_clip_th,
    output logic [NUM_CH-1:0]            ctrl_hc_enable,
    output logic [NUM_CH*TH_WIDTH-1:0]   ctrl_hc_th,
    output logic                         cpw_wr_en,
    output logic [NUM_CH-1:0]            cpw_wr_ch,
    output logic [7:0]                   cpw_wr_addr,
    output logic [15:0]                  cpw_wr_data_i,
    output logic [15:0]                  cpw_wr_data_q,
    output logic                         commit_pending
);

    typedef enum logic {IDLE, PENDING} state_t;

    localparam logic [31:0] BAD = 32'hDEADBEEF;

    logic [11:0] wa, ra;
    logic        wa_ok, ra_ok;

    // Anything above the 12-bit map must be zero to decode.
    assign wa    = wr_addr[11:0];
    assign ra    = rd_addr[11:0];
    assign wa_ok = (wr_addr >> 12) == '0;
    assign ra_ok = (rd_addr >> 12) == '0;

    logic wr_page, commit_now, commit_arm, cpw_hit, scratch_wr;

    assign wr_page    = wr_req && wa_ok && (wa[11:8] == 4'h1);
    assign scratch_wr = wr_req && wa_ok && (wa == 12'h003);
    assign commit_now = wr_req && wa_ok && (wa == 12'h002) && wr_data[0] &&  wr_data[1];
    assign commit_arm = wr_req && wa_ok && (wa == 12'h002) && wr_data[0] && !wr_data[1];
    assign cpw_hit    = wr_req && wa_ok && wa[11]
                        && ({29'd0, wa[10:8]} < NUM_CH) && ({24'd0, wa[7:0]} < CPW_DEPTH);

    // Commit FSM
    state_t state_q, state_d;
    logic   apply;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit_arm) state_d = PENDING;
            PENDING: if (commit_now || frame_sync) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        commit_pending = (state_q == PENDING);
        apply          = commit_now || ((state_q == PENDING) && frame_sync);
    end

    // Per-channel banks
    logic [NUM_CH-1:0]                 sh_pc, sh_hc, act_pc, act_hc, ch_wr, rd_clr;
    logic [NUM_CH-1:0][TH_WIDTH-1:0]   sh_det, sh_clip, sh_hc_th, act_det, act_clip, act_hc_th;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]  cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_wr[c] = wr_page && (wa[7:4] == 4'(c));

        cfr_regs_mc_ch #(
            .TH_WIDTH  (TH_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .wr_i        (ch_wr[c]),
            .wr_off_i    (wa[3:0]),
            .wdat_i      (wr_data[TH_WIDTH-1:0]),
            .apply_i     (apply),
            .rd_clr_i    (rd_clr[c]),
            .clip_i      (clip_event[c]),
            .sh_pc_en_o  (sh_pc[c]),
            .sh_hc_en_o  (sh_hc[c]),
            .sh_det_o    (sh_det[c]),
            .sh_clip_o   (sh_clip[c]),
            .sh_hc_o     (sh_hc_th[c]),
            .act_pc_en_o (act_pc[c]),
            .act_hc_en_o (act_hc[c]),
            .act_det_o   (act_det[c]),
            .act_clip_o  (act_clip[c]),
            .act_hc_o    (act_hc_th[c]),
            .cnt_o       (cnt[c])
        );
    end

    assign ctrl_pc_enable  = act_pc;
    assign ctrl_hc_enable  = act_hc;
    assign ctrl_pc_det_th  = act_det;
    assign ctrl_pc_clip_th = act_clip;
    assign ctrl_hc_th      = act_hc_th;

    function automatic logic [31:0] zx_th(input logic [TH_WIDTH-1:0] v);
        zx_th = '0;
        zx_th[TH_WIDTH-1:0] = v;
    endfunction

`ifdef CFR_REGS_MC_CLIP_CNT_EN
    function automatic logic [31:0] zx_cnt(input logic [CNT_WIDTH-1:0] v);
        zx_cnt = '0;
        zx_cnt[CNT_WIDTH-1:0] = v;
    endfunction
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, cnt};
`endif

    // Read mux and registered read port
    logic [31:0] scratch_q, rd_mux, rd_data_q, rd_data_d;
    logic        rd_ack_q, wr_ack_q;

    always_comb begin
        rd_mux = BAD;
        rd_clr = '0;
        if (ra_ok) begin
            case (ra)
                12'h000: rd_mux = ID;
                12'h001: rd_mux = {16'd0, 8'(NUM_CH), 8'(TH_WIDTH)};
                12'h002: rd_mux = {31'd0, commit_pending};
                12'h003: rd_mux = scratch_q;
                default: ;
            endcase
            if (ra[11:8] == 4'h1) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ra[7:4] == 4'(c)) begin
                        case (ra[3:0])
                            4'h0: rd_mux = {30'd0, sh_hc[c], sh_pc[c]};
                            4'h1: rd_mux = zx_th(sh_det[c]);
                            4'h2: rd_mux = zx_th(sh_clip[c]);
                            4'h3: rd_mux = zx_th(sh_hc_th[c]);
`ifdef CFR_REGS_MC_CLIP_CNT_EN
                            4'h4: begin
                                rd_mux    = zx_cnt(cnt[c]);
                                rd_clr[c] = rd_req;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
        end
        rd_data_d = rd_req ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            scratch_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_req;
            wr_ack_q  <= wr_req;
            if (scratch_wr) scratch_q <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
    assign wr_ack  = wr_ack_q;

    // CPW port: strobe lines up with wr_ack; payload holds between strobes.
    logic              cpw_en_q;
    logic [NUM_CH-1:0] cpw_ch_q, cpw_ch_d;
    logic [7:0]        cpw_addr_q;
    logic [15:0]       cpw_i_q, cpw_qd_q;

    always_comb begin
        cpw_ch_d = '0;
        for (int c = 0; c < NUM_CH; c++)
            cpw_ch_d[c] = (wa[10:8] == 3'(c));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpw_en_q   <= 1'b0;
            cpw_ch_q   <= '0;
            cpw_addr_q <= '0;
            cpw_i_q    <= '0;
            cpw_qd_q   <= '0;
        end else begin
            cpw_en_q <= cpw_hit;
            if (cpw_hit) begin
                cpw_ch_q   <= cpw_ch_d;
                cpw_addr_q <= wa[7:0];
                cpw_i_q    <= wr_data[15:0];
                cpw_qd_q   <= wr_data[31:16];
            end
        end
    end

    assign cpw_wr_en     = cpw_en_q;
    assign cpw_wr_ch     = cpw_ch_q;
    assign cpw_wr_addr   = cpw_addr_q;
    assign cpw_wr_data_i = cpw_i_q;
    assign cpw_wr_data_q = cpw_qd_q;

endmodule

// File: tb/tb_cfr_regs_mc.sv
// Bench for cfr_regs_mc: table-driven register reads checked through a scoreboard, plus
// hand-written commit, CPW, reset and clip-counter sequences.

module tb_cfr_regs_mc;

    localparam int          NCH = 2;
    localparam int          THW = 17;
    localparam logic [31:0] TID = 32'hC0FFEE01;
    localparam logic [31:0] BAD = 32'hDEADBEEF;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp;
    } rvec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [11:0]          wr_addr = '0, rd_addr = '0;
    logic                 wr_req = 1'b0, rd_req = 1'b0, frame_sync = 1'b0;
    logic [31:0]          wr_data = '0;
    logic [NCH-1:0]       clip_event = '0;
    logic                 wr_ack, rd_ack, cpw_wr_en, commit_pending;
    logic [31:0]          rd_data;
    logic [NCH-1:0]       ctrl_pc_enable, ctrl_hc_enable, cpw_wr_ch;
    logic [NCH*THW-1:0]   ctrl_pc_det_th, ctrl_pc_clip_th, ctrl_hc_th;
    logic [7:0]           cpw_wr_addr;
    logic [15:0]          cpw_wr_data_i, cpw_wr_data_q;

    always #5 clk = ~clk;

    cfr_regs_mc #(.ID(TID), .NUM_CH(NCH), .TH_WIDTH(THW)) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack),
        .frame_sync(frame_sync), .clip_event(clip_event),
        .ctrl_pc_enable(ctrl_pc_enable), .ctrl_pc_det_th(ctrl_pc_det_th),
        .ctrl_pc_clip_th(ctrl_pc_clip_th), .ctrl_hc_enable(ctrl_hc_enable),
        .ctrl_hc_th(ctrl_hc_th), .cpw_wr_en(cpw_wr_en), .cpw_wr_ch(cpw_wr_ch),
        .cpw_wr_addr(cpw_wr_addr), .cpw_wr_data_i(cpw_wr_data_i),
        .cpw_wr_data_q(cpw_wr_data_q), .commit_pending(commit_pending)
    );

    int    n_cmp = 0, n_err = 0;
    rvec_t exp_q[$];
    rvec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every rd_ack pops the value predicted when the read was issued.
    always @(negedge clk) begin
        if (!rst && rd_ack) begin
            if (exp_q.size() == 0) chk("rd_unexpected_ack", 64'd1, 64'd0);
            else begin
                rvec_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd_data@%03h", e.addr), {32'd0, rd_data}, {32'd0, e.exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e);
        exp_q.push_back('{a, e});
        rd_addr = a;
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        chk($sformatf("wr_ack@%03h", a), {63'd0, wr_ack}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{12'h000, TID});
        tbl.push_back('{12'h001, 32'h0000_0211});
        tbl.push_back('{12'h002, 32'h0});
        tbl.push_back('{12'h003, 32'h0});
        tbl.push_back('{12'h100, 32'h0});
        tbl.push_back('{12'h101, 32'h1FFFF});
        tbl.push_back('{12'h102, 32'h1FFFF});
        tbl.push_back('{12'h103, 32'h1FFFF});
        tbl.push_back('{12'h110, 32'h0});
        tbl.push_back('{12'h111, 32'h1FFFF});
        tbl.push_back('{12'h112, 32'h1FFFF});
        tbl.push_back('{12'h113, 32'h1FFFF});
`ifdef CFR_REGS_MC_CLIP_CNT_EN
        tbl.push_back('{12'h104, 32'h0});
`else
        tbl.push_back('{12'h104, BAD});
`endif
        tbl.push_back('{12'h105, BAD});
        tbl.push_back('{12'h120, BAD});
        tbl.push_back('{12'h905, BAD});
        tbl.push_back('{12'h3FF, BAD});

        // Reset state
        tick(); tick();
        chk("rst_pc_en", {62'd0, ctrl_pc_enable}, 64'd0);
        chk("rst_hc_en", {62'd0, ctrl_hc_enable}, 64'd0);
        chk("rst_det_th", {30'd0, ctrl_pc_det_th}, {30'd0, {NCH*THW{1'b1}}});
        chk("rst_hc_th", {30'd0, ctrl_hc_th}, {30'd0, {NCH*THW{1'b1}}});
        chk("rst_pending", {63'd0, commit_pending}, 64'd0);
        chk("rst_cpw_en", {63'd0, cpw_wr_en}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) rd(tbl[i].addr, tbl[i].exp);
        tick(); tick();
        chk("rd_hold", {32'd0, rd_data}, {32'd0, BAD});
        chk("rd_ack_idle", {63'd0, rd_ack}, 64'd0);

        // Scratch, and read-during-write returning the old value
        wr(12'h003, 32'hA5A55A5A);
        rd(12'h003, 32'hA5A55A5A);
        wr_addr = 12'h003; wr_data = 32'h12345678; wr_req = 1'b1;
        exp_q.push_back('{12'h003, 32'hA5A55A5A});
        rd_addr = 12'h003; rd_req = 1'b1;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        rd(12'h003, 32'h12345678);

        // Frame-aligned commit; upper bits beyond TH_WIDTH dropped
        wr(12'h101, 32'hFFFE0400);
        rd(12'h101, 32'h00400);
        wr(12'h002, 32'h1);
        chk("arm_pending", {63'd0, commit_pending}, 64'd1);
        chk("arm_det_unchanged", {47'd0, ctrl_pc_det_th[0 +: THW]}, 64'h1FFFF);
        rd(12'h002, 32'h1);
        tick();
        chk("arm_still_pending", {63'd0, commit_pending}, 64'd1);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("fs_det_applied", {47'd0, ctrl_pc_det_th[0 +: THW]}, 64'h00400);
        chk("fs_pending_clr", {63'd0, commit_pending}, 64'd0);

        // Immediate commit, coincident frame_sync irrelevant
        wr(12'h110, 32'h3);
        wr_addr = 12'h002; wr_data = 32'h3; wr_req = 1'b1; frame_sync = 1'b1;
        tick();
        wr_req = 1'b0; frame_sync = 1'b0;
        chk("now_pc_en", {62'd0, ctrl_pc_enable}, 64'b10);
        chk("now_hc_en", {62'd0, ctrl_hc_enable}, 64'b10);
        chk("now_pending", {63'd0, commit_pending}, 64'd0);

        // Arm with coincident frame_sync (ignored), repeat arm, then apply
        wr(12'h112, 32'h01234);
        wr_addr = 12'h002; wr_data = 32'h1; wr_req = 1'b1; frame_sync = 1'b1;
        tick();
        wr_req = 1'b0; frame_sync = 1'b0;
        chk("coinc_pending", {63'd0, commit_pending}, 64'd1);
        chk("coinc_clip_unchanged", {47'd0, ctrl_pc_clip_th[THW +: THW]}, 64'h1FFFF);
        wr(12'h111, 32'h00777);
        wr(12'h002, 32'h1);
        chk("rearm_pending", {63'd0, commit_pending}, 64'd1);
        chk("rearm_det_unchanged", {47'd0, ctrl_pc_det_th[THW +: THW]}, 64'h1FFFF);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("rearm_clip_applied", {47'd0, ctrl_pc_clip_th[THW +: THW]}, 64'h01234);
        chk("rearm_det_applied", {47'd0, ctrl_pc_det_th[THW +: THW]}, 64'h00777);

        // CPW back-to-back
        wr_data = 32'hBEEF1234; wr_req = 1'b1;
        wr_addr = 12'h905;
        tick();
        chk("cpw0_en", {63'd0, cpw_wr_en}, 64'd1);
        chk("cpw0_ch", {62'd0, cpw_wr_ch}, 64'b10);
        chk("cpw0_addr", {56'd0, cpw_wr_addr}, 64'd5);
        chk("cpw0_i", {48'd0, cpw_wr_data_i}, 64'h1234);
        chk("cpw0_q", {48'd0, cpw_wr_data_q}, 64'hBEEF);
        wr_addr = 12'h906;
        tick();
        wr_req = 1'b0;
        chk("cpw1_en", {63'd0, cpw_wr_en}, 64'd1);
        chk("cpw1_addr", {56'd0, cpw_wr_addr}, 64'd6);
        tick();
        chk("cpw_idle_en", {63'd0, cpw_wr_en}, 64'd0);
        chk("cpw_hold_addr", {56'd0, cpw_wr_addr}, 64'd6);
        wr(12'hA00, 32'h5555AAAA);
        chk("cpw_badch_en", {63'd0, cpw_wr_en}, 64'd0);
        wr(12'hC00, 32'h5555AAAA);
        chk("cpw_bad_en", {63'd0, cpw_wr_en}, 64'd0);
        chk("cpw_bad_i", {48'd0, cpw_wr_data_i}, 64'h1234);

`ifdef CFR_REGS_MC_CLIP_CNT_EN
        for (int i = 0; i < 3; i++) begin
            clip_event = 2'b01; tick();
            clip_event = 2'b00; tick();
        end
        rd(12'h104, 32'd3);
        clip_event = 2'b01;
        rd(12'h104, 32'd0);
        clip_event = 2'b00;
        rd(12'h104, 32'd1);
        rd(12'h114, 32'd0);
`endif

        // Asynchronous reset while a commit is pending
        wr(12'h103, 32'h00055);
        wr(12'h002, 32'h1);
        chk("prerst_pending", {63'd0, commit_pending}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pending", {63'd0, commit_pending}, 64'd0);
        chk("async_rst_pc_en", {62'd0, ctrl_pc_enable}, 64'd0);
        chk("async_rst_cpw_addr", {56'd0, cpw_wr_addr}, 64'd0);
        rst = 1'b0;
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        chk("postrst_hc_th", {30'd0, ctrl_hc_th}, {30'd0, {NCH*THW{1'b1}}});
        rd(12'h103, 32'h1FFFF);
        rd(12'h003, 32'h0);
        tick(); tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
